// File: rtl/hazard_pkg.sv
// hazard_pkg: shared forwarding codes, wait-state encodings and defaults for the hazard controller.
package hazard_pkg;
  localparam int REG_AW_DEF = 5;
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_IWAIT = 2'b01,
    ST_DWAIT = 2'b10
  } state_t;
endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// fwd_unit: combinational EX-stage operand forwarding selects.
//   i_rs1E/i_rs2E      EX source registers
//   i_rdM/i_reg_writeM MEM destination and write enable (higher priority)
//   i_rdW/i_reg_writeW WB destination and write enable
//   o_fwd_a/o_fwd_b    selects for operand A/B (FWD_RF, FWD_WB, FWD_MEM)
module fwd_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] i_rs1E,
  input  logic [REG_AW-1:0] i_rs2E,
  input  logic [REG_AW-1:0] i_rdM,
  input  logic              i_reg_writeM,
  input  logic [REG_AW-1:0] i_rdW,
  input  logic              i_reg_writeW,
  output logic [1:0]        o_fwd_a,
  output logic [1:0]        o_fwd_b
);
  logic w_m_ok, w_w_ok;
  // x0 is hardwired zero, so a write to it must never be forwarded
  assign w_m_ok  = i_reg_writeM && (i_rdM != '0);
  assign w_w_ok  = i_reg_writeW && (i_rdW != '0);
  assign o_fwd_a = (w_m_ok && i_rdM == i_rs1E) ? FWD_MEM : (w_w_ok && i_rdW == i_rs1E) ? FWD_WB : FWD_RF;
  assign o_fwd_b = (w_m_ok && i_rdM == i_rs2E) ? FWD_MEM : (w_w_ok && i_rdW == i_rs2E) ? FWD_WB : FWD_RF;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forward control for a 5-stage RISC-V pipeline with memory-wait FSM and watchdog.
//   Inputs : ID/EX/MEM/WB register indices and write enables, mem_readE, pc_srcE,
//            imem_ready, dmem_reqM, dmem_ready; clk, rst_n (async active-low).
//   Outputs: StallF/D/E/M, FlushD/E, ForwardAE/BE, wait_state (00 RUN, 01 IWAIT, 10 DWAIT),
//            err_timeout (sticky watchdog error).
//   Build option HAZARD_PERF_CNT_EN adds perf_stall_cnt, perf_flush_cnt, perf_lduse_cnt.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW         = REG_AW_DEF,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs1D,
  input  logic [REG_AW-1:0] rs2D,
  input  logic [REG_AW-1:0] rs1E,
  input  logic [REG_AW-1:0] rs2E,
  input  logic [REG_AW-1:0] rdE,
  input  logic              mem_readE,
  input  logic [REG_AW-1:0] rdM,
  input  logic              reg_writeM,
  input  logic [REG_AW-1:0] rdW,
  input  logic              reg_writeW,
  input  logic              pc_srcE,
  input  logic              imem_ready,
  input  logic              dmem_reqM,
  input  logic              dmem_ready,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic [1:0]        wait_state,
  output logic              err_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt,
  output logic [31:0]       perf_lduse_cnt
`endif
);
  localparam logic [CNT_W-1:0] TMAX = CNT_W'(TIMEOUT_CYCLES);
  state_t           r_state, w_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_err;
  logic             w_dwait, w_iwait, w_lw, w_br;
  logic [1:0]       w_fa, w_fb;
  fwd_unit #(.REG_AW(REG_AW)) u_fwd (
    .i_rs1E      (rs1E),
    .i_rs2E      (rs2E),
    .i_rdM       (rdM),
    .i_reg_writeM(reg_writeM),
    .i_rdW       (rdW),
    .i_reg_writeW(reg_writeW),
    .o_fwd_a     (w_fa),
    .o_fwd_b     (w_fb)
  );
  // a data wait freezes everything, so it masks load-use and branch resolution
  assign w_dwait = dmem_reqM && !dmem_ready;
  assign w_iwait = !imem_ready && !w_dwait;
  assign w_lw    = !w_dwait && mem_readE && (rdE != '0) && (rdE == rs1D || rdE == rs2D);
  assign w_br    = pc_srcE && !w_dwait;
  always_comb begin
    StallF    = rst_n && (w_dwait || w_iwait || w_lw);
    StallD    = rst_n && (w_dwait || w_lw);
    StallE    = rst_n && w_dwait;
    StallM    = rst_n && w_dwait;
    FlushD    = !rst_n || w_br || w_iwait;
    FlushE    = !rst_n || w_br || w_lw;
    ForwardAE = rst_n ? w_fa : FWD_RF;
    ForwardBE = rst_n ? w_fb : FWD_RF;
  end
  always_comb begin
    w_nxt     = (r_state == ST_RUN)   ? (w_dwait ? ST_DWAIT : w_iwait ? ST_IWAIT : ST_RUN) :
                (r_state == ST_DWAIT) ? (dmem_ready ? ST_RUN : ST_DWAIT) :
                                        (w_dwait ? ST_DWAIT : imem_ready ? ST_RUN : ST_IWAIT);
    w_cnt_nxt = (w_nxt != r_state || r_state == ST_RUN) ? '0 : (r_cnt == TMAX) ? r_cnt : r_cnt + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= r_err || (r_state != ST_RUN && w_cnt_nxt == TMAX);
    end
  end
  assign wait_state  = r_state;
  assign err_timeout = r_err;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_perf_stall, r_perf_flush, r_perf_lduse;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_stall <= '0;
      r_perf_flush <= '0;
      r_perf_lduse <= '0;
    end else begin
      r_perf_stall <= r_perf_stall + 32'(StallF);
      r_perf_flush <= r_perf_flush + 32'(w_br);
      r_perf_lduse <= r_perf_lduse + 32'(w_lw);
    end
  end
  assign perf_stall_cnt = r_perf_stall;
  assign perf_flush_cnt = r_perf_flush;
  assign perf_lduse_cnt = r_perf_lduse;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl.
module tb_hazard_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic       mem_readE, reg_writeM, reg_writeW, pc_srcE, imem_ready, dmem_reqM, dmem_ready;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, err_timeout;
  logic [1:0] ForwardAE, ForwardBE, wait_state;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt, perf_lduse_cnt;
`endif
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  hazard_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
    .rdE(rdE), .mem_readE(mem_readE), .rdM(rdM), .reg_writeM(reg_writeM),
    .rdW(rdW), .reg_writeW(reg_writeW), .pc_srcE(pc_srcE),
    .imem_ready(imem_ready), .dmem_reqM(dmem_reqM), .dmem_ready(dmem_ready),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .wait_state(wait_state), .err_timeout(err_timeout)
`ifdef HAZARD_PERF_CNT_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt), .perf_lduse_cnt(perf_lduse_cnt)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic idle();
    {rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW} = '0;
    {mem_readE, reg_writeM, reg_writeW, pc_srcE, dmem_reqM} = '0;
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
  endtask
  // drive point: mid-cycle, far from the rising edge; checks follow #1 later
  task automatic cyc();
    @(negedge clk);
  endtask
  task automatic chk_ctl(input string tag, input logic [5:0] exp);
    chk(tag, {26'b0, StallF, StallD, StallE, StallM, FlushD, FlushE}, {26'b0, exp});
  endtask
  initial begin
    rst_n = 1'b0;
    idle();
    rdM = 5'd5; reg_writeM = 1'b1; rs1E = 5'd5;
    #3;
    chk_ctl("reset_ctl", 6'b0000_11);
    chk("reset_fwdA", 32'(ForwardAE), 32'd0);
    chk("reset_ws", 32'(wait_state), 32'd0);
    chk("reset_err", 32'(err_timeout), 32'd0);
    cyc(); rst_n = 1'b1; idle();
    #1 chk_ctl("idle_ctl", 6'b0000_00);
    // forwarding priority
    cyc(); rdM = 5'd5; rdW = 5'd5; reg_writeM = 1'b1; reg_writeW = 1'b1; rs1E = 5'd5; rs2E = 5'd5;
    #1 chk("fwd_mem_A", 32'(ForwardAE), 32'd2); chk("fwd_mem_B", 32'(ForwardBE), 32'd2);
    cyc(); reg_writeM = 1'b0;
    #1 chk("fwd_wb_A", 32'(ForwardAE), 32'd1); chk("fwd_wb_B", 32'(ForwardBE), 32'd1);
    cyc(); reg_writeM = 1'b1; rdM = 5'd0; rdW = 5'd0; rs1E = 5'd0; rs2E = 5'd0;
    #1 chk("fwd_x0_A", 32'(ForwardAE), 32'd0); chk("fwd_x0_B", 32'(ForwardBE), 32'd0);
    cyc(); rdM = 5'd3; rdW = 5'd5; rs1E = 5'd5; rs2E = 5'd3;
    #1 chk("fwd_mix_A", 32'(ForwardAE), 32'd1); chk("fwd_mix_B", 32'(ForwardBE), 32'd2);
    // load-use
    cyc(); idle(); mem_readE = 1'b1; rdE = 5'd7; rs2D = 5'd7;
    #1 chk_ctl("lduse_ctl", 6'b1100_01);
    cyc(); rdE = 5'd8;
    #1 chk_ctl("lduse_gone", 6'b0000_00);
    cyc(); rdE = 5'd0; rs1D = 5'd0;
    #1 chk_ctl("lduse_x0", 6'b0000_00);
    // branch held during data wait
    cyc(); idle(); pc_srcE = 1'b1; dmem_reqM = 1'b1; dmem_ready = 1'b0;
    #1 chk_ctl("dw_br_c1", 6'b1111_00); chk("dw_ws_c1", 32'(wait_state), 32'd0);
    cyc();
    #1 chk_ctl("dw_br_c2", 6'b1111_00); chk("dw_ws_c2", 32'(wait_state), 32'd2);
    cyc();
    #1 chk_ctl("dw_br_c3", 6'b1111_00); chk("dw_ws_c3", 32'(wait_state), 32'd2);
    cyc(); dmem_ready = 1'b1;
    #1 chk_ctl("dw_resume", 6'b0000_11);
    cyc(); pc_srcE = 1'b0; dmem_reqM = 1'b0;
    #1 chk("dw_back_run", 32'(wait_state), 32'd0); chk_ctl("dw_back_ctl", 6'b0000_00);
    // instruction wait, then data wait arrives
    cyc(); imem_ready = 1'b0;
    #1 chk_ctl("iw_c1", 6'b1000_10); chk("iw_ws_c1", 32'(wait_state), 32'd0);
    cyc();
    #1 chk_ctl("iw_c2", 6'b1000_10); chk("iw_ws_c2", 32'(wait_state), 32'd1);
    cyc(); dmem_reqM = 1'b1; dmem_ready = 1'b0;
    #1 chk_ctl("iw_dw_ctl", 6'b1111_00); chk("iw_dw_ws", 32'(wait_state), 32'd1);
    cyc();
    #1 chk("iw_to_dw", 32'(wait_state), 32'd2);
    cyc(); idle();
    cyc();
    #1 chk("iw_dw_run", 32'(wait_state), 32'd0);
    // combined IF-side events
    cyc(); imem_ready = 1'b0; mem_readE = 1'b1; rdE = 5'd9; rs1D = 5'd9;
    #1 chk_ctl("iw_lduse", 6'b1100_11);
    cyc(); mem_readE = 1'b0; pc_srcE = 1'b1;
    #1 chk_ctl("iw_branch", 6'b1000_11);
    cyc(); idle();
    cyc();
    #1 chk("combo_run", 32'(wait_state), 32'd0); chk("pre_wd_err", 32'(err_timeout), 32'd0);
    // watchdog: timeout of 4 wait cycles
    cyc(); dmem_reqM = 1'b1; dmem_ready = 1'b0;
    cyc(); cyc(); cyc();
    #1 chk("wd_dw3_err", 32'(err_timeout), 32'd0);
    cyc(); cyc();
    #1 chk("wd_dw5_err", 32'(err_timeout), 32'd1); chk("wd_ws", 32'(wait_state), 32'd2);
    cyc(); cyc();
    #1 chk("wd_sat_err", 32'(err_timeout), 32'd1); chk("wd_still_wait", 32'(wait_state), 32'd2);
    cyc(); dmem_ready = 1'b1;
    cyc(); idle();
    #1 chk("wd_sticky", 32'(err_timeout), 32'd1); chk("wd_run", 32'(wait_state), 32'd0);
    // async reset in the middle of a data wait
    cyc(); dmem_reqM = 1'b1; dmem_ready = 1'b0;
    cyc();
    #1 chk("ar_pre_ws", 32'(wait_state), 32'd2);
    #1 rst_n = 1'b0;
    #1 chk("ar_ws", 32'(wait_state), 32'd0); chk_ctl("ar_ctl", 6'b0000_11);
    chk("ar_err", 32'(err_timeout), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
    chk("ar_perf_stall", perf_stall_cnt, 32'd0);
    chk("ar_perf_flush", perf_flush_cnt, 32'd0);
    chk("ar_perf_lduse", perf_lduse_cnt, 32'd0);
`endif
    cyc(); idle(); rst_n = 1'b1;
    cyc();
    #1 chk("post_rst_ws", 32'(wait_state), 32'd0); chk_ctl("post_rst_ctl", 6'b0000_00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Central hazard and stall controller for the 5-stage RISC-V pipeline. Drives StallF/StallD/FlushD into the IF/ID register and the matching controls for ID/EX and EX/MEM. Generates EX-stage forwarding selects, load-use stalls, branch flushes, and full-pipeline freezes on multi-cycle instruction and data memory waits. Includes a timeout watchdog.

Parameters:
REG_AW, 5, register index width
TIMEOUT_CYCLES, 255, wait-state cycles before err_timeout sets (max 2^CNT_W-1)
CNT_W, 8, watchdog counter width

Ports:
clk  in  1  pipeline clock
rst_n  in  1  asynchronous active-low reset
rs1D, rs2D  in  REG_AW  ID-stage source registers
rs1E, rs2E  in  REG_AW  EX-stage source registers
rdE  in  REG_AW  EX-stage destination
mem_readE  in  1  EX instruction is a load
rdM  in  REG_AW  MEM-stage destination
reg_writeM  in  1  MEM-stage writes register
rdW  in  REG_AW  WB-stage destination
reg_writeW  in  1  WB-stage writes register
pc_srcE  in  1  taken branch/jump resolved in EX
imem_ready  in  1  instruction memory data valid this cycle
dmem_reqM  in  1  MEM stage issues a load/store
dmem_ready  in  1  data memory completes this cycle
StallF, StallD, StallE, StallM  out  1  hold PC / IF-ID / ID-EX / EX-MEM
FlushD, FlushE  out  1  bubble IF-ID / ID-EX
ForwardAE, ForwardBE  out  2  00 regfile, 01 WB result, 10 MEM ALU result
wait_state  out  2  00 RUN, 01 IWAIT, 10 DWAIT
err_timeout  out  1  sticky watchdog error

Behaviour:
- Reset: async, rst_n low -> state RUN, counter 0, err_timeout 0. Outputs are combinational. While rst_n low: all stalls 0, FlushD=FlushE=1, forwards 00.
- Forwarding: ForwardAE=10 if reg_writeM && rdM!=0 && rdM==rs1E. Else 01 if reg_writeW && rdW!=0 && rdW==rs1E. Else 00. MEM has priority. ForwardBE uses rs2E with the same rules.
- Load-use: lw_stall = mem_readE && rdE!=0 && (rdE==rs1D || rdE==rs2D). Sets StallF=StallD=1 and FlushE=1.
- Branch: pc_srcE sets FlushD=1 and FlushE=1.
- Data wait: dwait = dmem_reqM && !dmem_ready. Sets StallF=StallD=StallE=StallM=1 in the same cycle (Mealy). Forces FlushD=FlushE=0 and suppresses lw_stall and branch flush. The branch stays held in EX and flushes on the resume cycle.
- Instruction wait: iwait = !imem_ready && !dwait. Sets StallF=1 and FlushD=1, inserting a bubble. Later stages advance.
- Combining IF-side events: if iwait and lw_stall coincide, StallD=1 wins over FlushD (IF/ID gives stall priority). FlushD is still driven, but the IF/ID register ignores it. If iwait and pc_srcE coincide, FlushD=1 and FlushE=1.
- FSM, registered on clk:
  - RUN -> DWAIT on dwait; RUN -> IWAIT on iwait; else stay in RUN.
  - DWAIT -> RUN when dmem_ready.
  - IWAIT -> DWAIT on dwait; IWAIT -> RUN when imem_ready.
  - A one-cycle wait (request and ready in the same cycle) never leaves RUN.
- Watchdog: counter clears on every state transition and increments each cycle in IWAIT/DWAIT. It saturates at TIMEOUT_CYCLES, and err_timeout sets on reaching it. err_timeout stays set until reset. The FSM keeps waiting; there is no forced recovery.
- Reset mid-wait: immediate return to RUN. Counter clears.

Optional Feature:
HAZARD_PERF_CNT_EN. When defined, adds three 32-bit outputs, all cleared on reset, wrap-around on overflow:
- perf_stall_cnt: counts cycles with StallF=1.
- perf_flush_cnt: counts pc_srcE cycles not suppressed by dwait.
- perf_lduse_cnt: counts effective lw_stall cycles.
When undefined, these ports and registers are absent and behaviour is otherwise identical.

Decomposition:
- Shared package hazard_pkg holds:
  - FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10
  - state encodings ST_RUN, ST_IWAIT, ST_DWAIT
  - the REG_AW default
- One natural sub-module, fwd_unit: purely combinational forwarding logic, instantiated once and producing both selects.
- FSM, watchdog and stall/flush priority stay in hazard_ctrl.

Test Plan:
- Forward priority: rdM=rdW=5, reg_writeM=reg_writeW=1, rs1E=5 -> ForwardAE=10. With reg_writeM=0 -> 01. With rdM=rdW=0 -> 00.
- Load-use: mem_readE=1, rdE=7, rs2D=7 -> StallF=StallD=FlushE=1, FlushD=0 for one cycle. Then rdE changes -> all 0.
- Branch during data wait: pc_srcE=1, dmem_reqM=1, dmem_ready=0 for 3 cycles -> all stalls 1, flushes 0, wait_state=10. On the cycle dmem_ready=1 -> FlushD=FlushE=1, then back to RUN.
- Instruction wait: imem_ready=0 for 2 cycles -> StallF=1, FlushD=1, StallE=0, wait_state=01. IWAIT->DWAIT when dwait arrives.
- Watchdog: TIMEOUT_CYCLES=4, dmem_ready held 0 -> err_timeout rises on the 4th DWAIT cycle and stays 1 after dmem_ready=1, until rst_n pulses low.
- Async reset mid-DWAIT: drop rst_n between clock edges -> wait_state=00 and FlushD=FlushE=1 immediately. With HAZARD_PERF_CNT_EN, all perf counters read 0.
